// File: rtl/count_bcd_converter_pkg.sv
// Shared types and sizing constants for the sequential binary-to-BCD converter.
// The FSM state encoding and the iteration count live here.
package count_bcd_converter_pkg;

    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;
    localparam int ITERATIONS = 8;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/count_bcd_converter_bcd_digit_adj.sv
// Combinational double-dabble correction for one BCD digit.
// A digit of 5 or more gets 3 added so that the following shift carries correctly.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/count_bcd_converter.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per clock).
// Optionally self-starts whenever the input differs from the last converted value.
module count_bcd_converter
    import count_bcd_converter_pkg::*;
#(
    parameter logic AUTO_CONVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    state_t               state_reg;
    state_t               state_next;
    logic [BCD_W-1:0]     scratch_reg;
    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W-1:0]     scratch_next;
    logic [BIN_W-1:0]     bin_reg;
    logic [BIN_W-1:0]     bin_next;
    logic [BIN_W-1:0]     last_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [3:0]           hundreds_reg;
    logic [3:0]           tens_reg;
    logic [3:0]           ones_reg;
    logic                 accept;
    logic                 last_iter;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit    (scratch_reg[gi*4 +: 4]),
                .adjusted (scratch_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Adjusted digits and the remaining binary bits shift left together as one word.
    assign {scratch_next, bin_next} = {scratch_adj, bin_reg} << 1;
    assign last_iter = (cnt_reg == CNT_W'(ITERATIONS - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start || (AUTO_CONVERT && (bin != last_reg))) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            scratch_reg  <= '0;
            bin_reg      <= '0;
            last_reg     <= '0;
            cnt_reg      <= '0;
            hundreds_reg <= '0;
            tens_reg     <= '0;
            ones_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                bin_reg     <= bin;
                last_reg    <= bin;
                scratch_reg <= '0;
                cnt_reg     <= '0;
            end else if (state_reg == SHIFT) begin
                scratch_reg <= scratch_next;
                bin_reg     <= bin_next;
                cnt_reg     <= cnt_reg + 1'b1;
                if (last_iter) begin
                    hundreds_reg <= scratch_next[11:8];
                    tens_reg     <= scratch_next[7:4];
                    ones_reg     <= scratch_next[3:0];
                end
            end
        end
    end

    assign hundreds = hundreds_reg;
    assign tens     = tens_reg;
    assign ones     = ones_reg;

endmodule

// File: doc/count_bcd_converter.md
COUNT_BCD_CONVERTER -- requirements
Module: count_bcd_converter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high (ports clk and reset).
REQ-002 Parameter: AUTO_CONVERT, default 1'b0; 1 = self-start a conversion whenever bin differs from the last converted value.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: bin  input  8  unsigned binary value from the 8-bit up-counter output.
REQ-006 Port: start  input  1  conversion request, sampled on clk rising edge.
REQ-007 Port: busy  output  1  high while a conversion is iterating.
REQ-008 Port: done  output  1  single-cycle pulse, result valid and just updated.
REQ-009 Port: hundreds  output  4  BCD hundreds digit, range 0-2.
REQ-010 Port: tens  output  4  BCD tens digit, range 0-9.
REQ-011 Port: ones  output  4  BCD ones digit, range 0-9.

Function
REQ-012 Conversion SHALL use the sequential shift-add-3 (double dabble) algorithm, one bit per clock.
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 IDLE->SHIFT SHALL occur when start=1 is sampled in IDLE; at that edge bin is captured and the 12-bit BCD scratch and the iteration counter are cleared.
REQ-015 In SHIFT, each edge SHALL add 3 to every scratch digit >=5, then shift {scratch, captured bin} left by 1.
REQ-016 SHIFT->DONE SHALL occur on the edge completing iteration 8; on that same edge the scratch digits SHALL load into hundreds, tens and ones.
REQ-017 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-018 busy SHALL be 1 exactly in SHIFT (8 cycles); done SHALL be 1 exactly in DONE (1 cycle).
REQ-019 Latency: done SHALL be high in the cycle following the 8th edge after the accepting edge.
REQ-020 start SHALL be ignored in SHIFT and DONE; with start held high, a new conversion SHALL be accepted every 10 cycles.
REQ-021 Changes on bin after the accepting edge SHALL NOT affect the current result.
REQ-022 hundreds, tens and ones SHALL hold their last result except on the DONE-entry edge.
REQ-023 With AUTO_CONVERT=1, IDLE SHALL treat (bin != last-converted value) as start, OR-ed with the start port.
REQ-024 Every result SHALL satisfy 100*hundreds + 10*tens + ones == captured bin for all 0-255.

Reset
REQ-025 While reset=1, the block SHALL force state=IDLE, busy=0, done=0, hundreds=tens=ones=0, clear the scratch and counter, and set last-converted=0, without waiting for a clock.
REQ-026 A reset during SHIFT SHALL abort the conversion; no done pulse SHALL follow.
REQ-027 The first start accepted after reset deasserts SHALL behave identically to any other start.

Structure
REQ-028 A shared package SHALL hold the state enum typedef and the constants BIN_W=8, BCD_DIGITS=3 and ITERATIONS=8.
REQ-029 A combinational sub-module bcd_digit_adj (4-bit in, 4-bit out: add 3 if >=5) SHALL be instantiated once per digit.

Verification
REQ-030 bin=0, start pulse -> after 8 busy cycles, done=1 with hundreds/tens/ones=0/0/0.
REQ-031 bin=255, start -> 2/5/5; bin=100 -> 1/0/0; bin=99 -> 0/9/9; an exhaustive sweep 0-255 SHALL match the reference model.
REQ-032 Start held high, bin=42 then 43 -> done pulses spaced 10 cycles apart, results 0/4/2 then 0/4/3; start during busy is ignored.
REQ-033 bin changed from 17 to 200 one cycle after acceptance -> result 0/1/7.
REQ-034 reset asserted mid-SHIFT (iteration 4) -> busy=0 immediately, outputs 0/0/0, no done; next start converts correctly.
REQ-035 AUTO_CONVERT=1, bin steps 0->1->2 while start=0 -> one conversion per change, results 0/0/1 then 0/0/2; static bin -> no further done pulses.
